// File: rtl/demux_1x8_collect.sv
// 1-to-8 bit collector: steers (sel, din) beats into an 8-bit frame and presents it on a valid/ready port.
// Optional partial-frame idle timeout is enabled by defining DEMUX_TIMEOUT_EN.
module demux_1x8_collect #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic [2:0] sel,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] dout,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       dup_err,
    output logic       timeout
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..255");
    end

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t     state;
    logic [7:0] shift;
    logic [7:0] mask;
    logic [7:0] shift_nxt;
    logic [7:0] mask_nxt;
    logic       accept;
    logic       expire;

    assign in_ready = rst_n && (state == COLLECT);
    assign accept   = in_valid && in_ready;

    // Frame contents as they would be after merging the current beat.
    always_comb begin
        shift_nxt      = shift;
        mask_nxt       = mask;
        shift_nxt[sel] = din;
        mask_nxt[sel]  = 1'b1;
    end

`ifdef DEMUX_TIMEOUT_EN
    logic [7:0] idle_cnt;

    // An accept on the expiry cycle wins, so expiry requires no accept.
    assign expire = (state == COLLECT) && (mask != 8'h00) && !accept &&
                    (idle_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt <= 8'h00;
            timeout  <= 1'b0;
        end else begin
            timeout <= expire;
            if (state != COLLECT || mask == 8'h00 || accept || expire)
                idle_cnt <= 8'h00;
            else
                idle_cnt <= idle_cnt + 8'h01;
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= COLLECT;
            shift     <= 8'h00;
            mask      <= 8'h00;
            dout      <= 8'h00;
            out_valid <= 1'b0;
            dup_err   <= 1'b0;
        end else begin
            dup_err <= accept && mask[sel];
            case (state)
                COLLECT: begin
                    if (accept) begin
                        if (mask_nxt == 8'hFF) begin
                            dout      <= shift_nxt;
                            out_valid <= 1'b1;
                            mask      <= 8'h00;
                            shift     <= 8'h00;
                            state     <= HOLD;
                        end else begin
                            shift <= shift_nxt;
                            mask  <= mask_nxt;
                        end
                    end else if (expire) begin
                        mask  <= 8'h00;
                        shift <= 8'h00;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_demux_1x8_collect.sv
// Directed bench for demux_1x8_collect; covers both DEMUX_TIMEOUT_EN builds.
module tb_demux_1x8_collect;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din;
    logic [2:0] sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dout;
    logic       out_valid;
    logic       out_ready;
    logic       dup_err;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    demux_1x8_collect #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dup_err   (dup_err),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [2:0] s, input logic d);
        sel      = s;
        din      = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        logic [2:0] ord [8];

        rst_n = 1'b0; in_valid = 1'b0; din = 1'b0; sel = 3'd0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dout", dout, 8'h00);
        chk("rst_dup", dup_err, 0);
        chk("rst_timeout", timeout, 0);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", in_ready, 1);

        // In-order frame A5
        v = 8'hA5;
        for (int i = 0; i < 8; i++) beat(3'(i), v[i]);
        chk("a5_valid", out_valid, 1);
        chk("a5_dout", dout, 8'hA5);
        chk("a5_in_ready", in_ready, 0);
        chk("a5_dup", dup_err, 0);
        tick();
        chk("a5_release", out_valid, 0);
        chk("a5_ready_back", in_ready, 1);

        // Scrambled order frame 3C
        v = 8'h3C;
        ord = '{3'd7, 3'd3, 3'd0, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4};
        for (int i = 0; i < 8; i++) begin
            beat(ord[i], v[ord[i]]);
            if (i == 6) chk("3c_not_early", out_valid, 0);
        end
        chk("3c_dout", dout, 8'h3C);
        tick();

        // Duplicate write on bit1
        beat(3'd0, 1'b1);
        beat(3'd1, 1'b1);
        chk("dup_none", dup_err, 0);
        beat(3'd1, 1'b0);
        chk("dup_pulse", dup_err, 1);
        chk("dup_no_complete", out_valid, 0);
        for (int i = 2; i < 8; i++) begin
            beat(3'(i), 1'b1);
            if (i == 2) chk("dup_one_cycle", dup_err, 0);
        end
        chk("dup_dout", dout, 8'hFD);
        chk("dup_valid", out_valid, 1);
        tick();

        // Backpressure on frame 81
        out_ready = 1'b0;
        v = 8'h81;
        for (int i = 0; i < 8; i++) beat(3'(i), v[i]);
        sel = 3'd0; din = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_dout", dout, 8'h81);
            chk("bp_valid", out_valid, 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release", out_valid, 0);
        chk("bp_ready_back", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_next_taken", out_valid, 0);

        // Reset mid-frame (4 beats total including the one above)
        for (int i = 1; i < 4; i++) beat(3'(i), 1'b1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_dout", dout, 8'h00);
        chk("mid_rst_dup", dup_err, 0);
        rst_n = 1'b1;
        v = 8'h0F;
        for (int i = 7; i >= 0; i--) begin
            beat(3'(i), v[i]);
            if (i == 4) chk("rst_no_contam", out_valid, 0);
        end
        chk("0f_dout", dout, 8'h0F);
        chk("0f_valid", out_valid, 1);
        tick();

        // Partial frame then idle gap
        v = 8'h5A;
        for (int i = 0; i < 3; i++) beat(3'(i), v[i]);
        for (int k = 1; k <= 16; k++) begin
            tick();
`ifdef DEMUX_TIMEOUT_EN
            chk("to_pulse", timeout, (k == 16) ? 8'h01 : 8'h00);
`else
            chk("to_never", timeout, 0);
`endif
        end
`ifdef DEMUX_TIMEOUT_EN
        tick();
        chk("to_one_cycle", timeout, 0);
        for (int i = 7; i >= 0; i--) begin
            beat(3'(i), v[i]);
            if (i == 3) chk("to_mask_cleared", out_valid, 0);
        end
        chk("to_dout", dout, 8'h5A);
        chk("to_valid", out_valid, 1);
`else
        for (int i = 3; i < 8; i++) beat(3'(i), v[i]);
        chk("noto_dout", dout, 8'h5A);
        chk("noto_valid", out_valid, 1);
`endif
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
